uart_msg_rx: RTL and testbench

Oversampling UART message receiver: the receive end of the length-prefixed messages that `uart_tx` serialises from its `full_data` word. It samples `in_bit` at FREQ_COEF system clocks per bit and deframes 8N1 bytes. The first byte is a length header L, followed by L payload bytes. The block reassembles them into a word with the same layout as the transmitter's `full_data`, so a loopback compare is a plain equality. It sits on the fast CLK domain between the pad and the command decoder.

---
 rtl/uart_msg_rx.sv | 155 +++++++++++++++
 tb/tb_uart_msg_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_msg_rx.sv
// uart_msg_rx: oversampling 8N1 receiver that reassembles length-prefixed messages.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   in_bit     serial line, idles high, asynchronous to CLK
//   full_data  last good message; payload byte k at [BYTE_SIZE*k +: BYTE_SIZE],
//              length in byte NB-2, top byte zero
//   out_valid  one-cycle pulse when full_data is updated
//   frame_err  one-cycle pulse when a message is aborted
//   busy       high from start-bit qualification until the message completes or aborts
module uart_msg_rx #(
    parameter int FULL_DATA_SIZE = 40,
    parameter int BYTE_SIZE      = 8,
    parameter int FREQ_COEF      = 4,
    parameter int TIMEOUT_BITS   = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_bit,
    output logic [FULL_DATA_SIZE-1:0] full_data,
    output logic                      out_valid,
    output logic                      frame_err,
    output logic                      busy
);
    localparam int NB      = FULL_DATA_SIZE / BYTE_SIZE;
    localparam int MAX_LEN = NB - 2;
    localparam int PW      = MAX_LEN * BYTE_SIZE;
    localparam int CW      = $clog2(FREQ_COEF);
    localparam int BW      = $clog2(BYTE_SIZE);
    localparam int LW      = $clog2(NB);
    localparam int TO      = TIMEOUT_BITS * FREQ_COEF;
    localparam int TW      = $clog2(TO);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_st_t;
    typedef enum logic {HDR, PAY} phase_t;

    bit_st_t               st;
    phase_t                phase;
    logic                  sync1, line;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic [BYTE_SIZE-1:0]  shreg, len;
    logic [LW-1:0]         byte_cnt;
    logic [PW-1:0]         pay, pay_nxt;
    logic [TW-1:0]         tcnt;

    // Staging word with the byte just deframed merged in at the current slot,
    // so the final payload byte can complete the message in the same cycle.
    always_comb begin
        pay_nxt = pay;
        pay_nxt[byte_cnt*BYTE_SIZE +: BYTE_SIZE] = shreg;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1     <= 1'b1;
            line      <= 1'b1;
            st        <= IDLE;
            phase     <= HDR;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            len       <= '0;
            byte_cnt  <= '0;
            pay       <= '0;
            tcnt      <= '0;
            full_data <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync1     <= in_bit;
            line      <= sync1;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            case (st)
                IDLE: begin
                    cnt <= '0;
                    if (!line) begin
                        st   <= START;
                        busy <= 1'b1;
                        tcnt <= '0;
                    end else if (phase == PAY) begin
                        // Inter-byte gap inside a message is bounded.
                        if (tcnt == TW'(TO - 1)) begin
                            frame_err <= 1'b1;
                            phase     <= HDR;
                            busy      <= 1'b0;
                            tcnt      <= '0;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                end
                START: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(FREQ_COEF/2 - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (line) begin
                            // Glitch: drop back silently; a message in progress stays busy.
                            st   <= IDLE;
                            busy <= (phase == PAY);
                        end else begin
                            st <= DATA;
                        end
                    end
                end
                DATA: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(FREQ_COEF - 1)) begin
                        cnt     <= '0;
                        shreg   <= {line, shreg[BYTE_SIZE-1:1]};
                        bit_idx <= bit_idx + BW'(1);
                        if (bit_idx == BW'(BYTE_SIZE - 1))
                            st <= STOP;
                    end
                end
                STOP: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(FREQ_COEF - 1)) begin
                        cnt <= '0;
                        st  <= IDLE;
                        if (!line || (phase == HDR && shreg > BYTE_SIZE'(MAX_LEN))) begin
                            frame_err <= 1'b1;
                            phase     <= HDR;
                            busy      <= 1'b0;
                        end else if (phase == HDR) begin
                            if (shreg == '0) begin
                                full_data <= '0;
                                out_valid <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                len      <= shreg;
                                byte_cnt <= '0;
                                pay      <= '0;
                                phase    <= PAY;
                            end
                        end else begin
                            pay      <= pay_nxt;
                            byte_cnt <= byte_cnt + LW'(1);
                            if (BYTE_SIZE'(byte_cnt) + BYTE_SIZE'(1) == len) begin
                                full_data <= {BYTE_SIZE'(0), len, pay_nxt};
                                out_valid <= 1'b1;
                                busy      <= 1'b0;
                                phase     <= HDR;
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_msg_rx.sv
// tb_uart_msg_rx: directed bench for uart_msg_rx at default parameters.
module tb_uart_msg_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_bit = 1'b1;
    logic [39:0] full_data;
    logic        out_valid, frame_err, busy;
    int          n_cmp = 0, n_err = 0, ov_cnt = 0, fe_cnt = 0;

    uart_msg_rx dut (
        .CLK(clk), .RST(rst), .in_bit(in_bit),
        .full_data(full_data), .out_valid(out_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) ov_cnt++;
        if (frame_err) fe_cnt++;
    end

    task automatic send_bit(input logic v);
        in_bit = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (full_data !== 40'h0) begin n_err++; $display("FAIL reset_full_data: got %h want 0", full_data); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_lengths;
        int ov0;
        ov0 = ov_cnt;
        send_byte(8'h02, 1'b1); send_byte(8'h47, 1'b1); send_byte(8'hbb, 1'b1);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL len2_valid: got %b want 1", out_valid); end
        n_cmp++; if (full_data !== 40'h00_02_00_bb_47) begin n_err++; $display("FAIL len2_data: got %h want 000200bb47", full_data); end
        send_byte(8'h01, 1'b1); send_byte(8'h47, 1'b1);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL len1_valid: got %b want 1", out_valid); end
        n_cmp++; if (full_data !== 40'h00_01_00_00_47) begin n_err++; $display("FAIL len1_data: got %h want 0001000047", full_data); end
        send_byte(8'h00, 1'b1);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL len0_valid: got %b want 1", out_valid); end
        n_cmp++; if (full_data !== 40'h0) begin n_err++; $display("FAIL len0_data: got %h want 0", full_data); end
        repeat (4) @(negedge clk);
        n_cmp++; if (ov_cnt - ov0 !== 3) begin n_err++; $display("FAIL len_pulses: got %0d want 3", ov_cnt - ov0); end
    endtask

    task automatic test_glitch;
        int ov0, fe0;
        logic saw;
        ov0 = ov_cnt; fe0 = fe_cnt; saw = 1'b0;
        in_bit = 1'b0;
        @(negedge clk);
        in_bit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy === 1'b1) saw = 1'b1;
        end
        n_cmp++; if (saw !== 1'b1) begin n_err++; $display("FAIL glitch_busy_seen: got %b want 1", saw); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
        repeat (20) @(negedge clk);
        n_cmp++; if (ov_cnt - ov0 !== 0 || fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL glitch_pulses: got ov %0d fe %0d want 0 0", ov_cnt - ov0, fe_cnt - fe0); end
    endtask

    task automatic test_back_to_back;
        int ov0;
        ov0 = ov_cnt;
        send_byte(8'h03, 1'b1); send_byte(8'h47, 1'b1); send_byte(8'hbb, 1'b1); send_byte(8'haa, 1'b1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_early_valid: got %b want 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_latency_valid: got %b want 1", out_valid); end
        n_cmp++; if (full_data !== 40'h00_03_aa_bb_47) begin n_err++; $display("FAIL b2b_data: got %h want 0003aabb47", full_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy: got %b want 0", busy); end
        repeat (4) @(negedge clk);
        n_cmp++; if (ov_cnt - ov0 !== 1) begin n_err++; $display("FAIL b2b_pulses: got %0d want 1", ov_cnt - ov0); end
    endtask

    task automatic test_bad_stop;
        int ov0, fe0;
        ov0 = ov_cnt; fe0 = fe_cnt;
        send_byte(8'h03, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b0);
        in_bit = 1'b1;
        @(negedge clk);
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL stop_frame_err: got %b want 1", frame_err); end
        n_cmp++; if (full_data !== 40'h00_03_aa_bb_47) begin n_err++; $display("FAIL stop_data_kept: got %h want 0003aabb47", full_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b want 0", busy); end
        repeat (8) @(negedge clk);
        n_cmp++; if (fe_cnt - fe0 !== 1 || ov_cnt - ov0 !== 0) begin n_err++; $display("FAIL stop_pulses: got fe %0d ov %0d want 1 0", fe_cnt - fe0, ov_cnt - ov0); end
        send_byte(8'h02, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || full_data !== 40'h00_02_00_22_11) begin n_err++; $display("FAIL stop_recover: got %b %h want 1 0002002211", out_valid, full_data); end
    endtask

    task automatic test_bad_header;
        send_byte(8'h05, 1'b1);
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL hdr_err_early: got %b want 0", frame_err); end
        @(negedge clk);
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL hdr_err: got %b want 1", frame_err); end
        @(negedge clk);
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL hdr_err_width: got %b want 0", frame_err); end
        n_cmp++; if (full_data !== 40'h00_02_00_22_11) begin n_err++; $display("FAIL hdr_data_kept: got %h want 0002002211", full_data); end
        send_byte(8'h01, 1'b1); send_byte(8'h5a, 1'b1);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || full_data !== 40'h00_01_00_00_5a) begin n_err++; $display("FAIL hdr_phase_back: got %b %h want 1 000100005a", out_valid, full_data); end
    endtask

    task automatic test_timeout;
        send_byte(8'h02, 1'b1); send_byte(8'h33, 1'b1);
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (k == 10) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL to_busy_gap: got %b want 1", busy); end
            end
            if (k == 64) begin
                n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", frame_err); end
            end
        end
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL to_expire: got %b want 1", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_busy: got %b want 0", busy); end
        n_cmp++; if (full_data !== 40'h00_01_00_00_5a) begin n_err++; $display("FAIL to_data_kept: got %h want 000100005a", full_data); end
    endtask

    task automatic test_reset_mid;
        int ov0, fe0;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
        rst = 1'b1; in_bit = 1'b1;
        #1;
        n_cmp++; if (full_data !== 40'h0 || out_valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid: got %h %b %b %b want 0 0 0 0", full_data, out_valid, frame_err, busy); end
        @(negedge clk);
        ov0 = ov_cnt; fe0 = fe_cnt;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (ov_cnt - ov0 !== 0 || fe_cnt - fe0 !== 0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_release: got ov %0d fe %0d busy %b want 0 0 0", ov_cnt - ov0, fe_cnt - fe0, busy); end
        send_byte(8'h01, 1'b1); send_byte(8'hc3, 1'b1);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || full_data !== 40'h00_01_00_00_c3) begin n_err++; $display("FAIL rst_after_msg: got %b %h want 1 00010000c3", out_valid, full_data); end
    endtask

    initial begin
        test_reset;
        test_lengths;
        test_glitch;
        test_back_to_back;
        test_bad_stop;
        test_bad_header;
        test_timeout;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
